// File: rtl/lcd_ctrl_param_if.sv
// Host-side bus of lcd_ctrl_param: command handshake, IROM read port, IRB write port.
// The address width is derived from the frame size and is not a free parameter.
interface lcd_ctrl_param_if #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8,
   parameter int DW    = 8
);
   localparam int AW = $clog2(IMG_W * IMG_H);

   logic [3:0]    cmd;
   logic          cmd_valid;
   logic [DW-1:0] IROM_Q;
   logic          IROM_EN;
   logic [AW-1:0] IROM_A;
   logic          IRB_RW;
   logic [DW-1:0] IRB_D;
   logic [AW-1:0] IRB_A;
   logic          busy;
   logic          done;

   modport slave (
      input  cmd, cmd_valid, IROM_Q,
      output IROM_EN, IROM_A, IRB_RW, IRB_D, IRB_A, busy, done
   );

   modport master (
      output cmd, cmd_valid, IROM_Q,
      input  IROM_EN, IROM_A, IRB_RW, IRB_D, IRB_A, busy, done
   );
endinterface

// File: rtl/lcd_ctrl_param.sv
// Image display controller: loads an IMG_W x IMG_H frame from IROM, edits a 2x2 window, dumps to IRB.
// Optional max/min commands (8/9) are built only when LCD_CTRL_MAXMIN_EN is defined.
module lcd_ctrl_param #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8,
   parameter int DW    = 8
) (
   input  logic               clk,
   input  logic               reset,
   lcd_ctrl_param_if.slave    bus
);
   localparam int N  = IMG_W * IMG_H;
   localparam int AW = $clog2(N);
   localparam int XW = $clog2(IMG_W);
   localparam int YW = $clog2(IMG_H);

   localparam logic [XW-1:0] X_MID  = XW'(IMG_W / 2);
   localparam logic [YW-1:0] Y_MID  = YW'(IMG_H / 2);
   localparam logic [XW-1:0] X_MAX  = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_MAX  = YW'(IMG_H - 1);
   localparam logic [XW-1:0] X_ONE  = XW'(1);
   localparam logic [YW-1:0] Y_ONE  = YW'(1);
   localparam logic [AW-1:0] A_ZERO = AW'(0);
   localparam logic [AW-1:0] A_ONE  = AW'(1);
   localparam logic [AW-1:0] A_LAST = AW'(N - 1);

   localparam logic [3:0] CMD_WRITE = 4'd0;
   localparam logic [3:0] CMD_UP    = 4'd1;
   localparam logic [3:0] CMD_DOWN  = 4'd2;
   localparam logic [3:0] CMD_LEFT  = 4'd3;
   localparam logic [3:0] CMD_RIGHT = 4'd4;
   localparam logic [3:0] CMD_AVG   = 4'd5;
   localparam logic [3:0] CMD_MIRX  = 4'd6;
   localparam logic [3:0] CMD_MIRY  = 4'd7;
`ifdef LCD_CTRL_MAXMIN_EN
   localparam logic [3:0] CMD_MAX   = 4'd8;
   localparam logic [3:0] CMD_MIN   = 4'd9;
`endif

   typedef enum logic [2:0] {
      S_LOAD,
      S_IDLE,
      S_EXEC,
      S_WRITE,
      S_DONE
   } state_e;

   state_e        r_state;
   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic [3:0]    r_cmd;
   logic          r_irom_en;
   logic [AW-1:0] r_irom_a;
   logic          r_irb_rw;
   logic [DW-1:0] r_irb_d;
   logic [AW-1:0] r_irb_a;
   logic          r_busy;
   logic          r_done;

   logic [DW-1:0] r_buf [N];

   // Window corners: since IMG_W is a power of two, address y*IMG_W+x is simply {y, x}.
   logic [XW-1:0] w_xm1;
   logic [YW-1:0] w_ym1;
   logic [AW-1:0] w_a0, w_a1, w_a2, w_a3;
   logic [DW-1:0] w_p0, w_p1, w_p2, w_p3;
   logic [DW-1:0] w_n0, w_n1, w_n2, w_n3;
   logic [DW+1:0] w_sum;
   logic [DW-1:0] w_avg;
   logic [AW-1:0] w_irb_next;

   assign w_xm1 = r_x - X_ONE;
   assign w_ym1 = r_y - Y_ONE;
   assign w_a0  = {w_ym1, w_xm1};
   assign w_a1  = {w_ym1, r_x};
   assign w_a2  = {r_y,   w_xm1};
   assign w_a3  = {r_y,   r_x};

   assign w_p0 = r_buf[w_a0];
   assign w_p1 = r_buf[w_a1];
   assign w_p2 = r_buf[w_a2];
   assign w_p3 = r_buf[w_a3];

   assign w_sum = {2'b00, w_p0} + {2'b00, w_p1} + {2'b00, w_p2} + {2'b00, w_p3};
   assign w_avg = w_sum[DW+1:2];

   assign w_irb_next = r_irb_a + A_ONE;

`ifdef LCD_CTRL_MAXMIN_EN
   logic [DW-1:0] w_max01, w_max23, w_max;
   logic [DW-1:0] w_min01, w_min23, w_min;

   assign w_max01 = (w_p0 > w_p1) ? w_p0 : w_p1;
   assign w_max23 = (w_p2 > w_p3) ? w_p2 : w_p3;
   assign w_max   = (w_max01 > w_max23) ? w_max01 : w_max23;
   assign w_min01 = (w_p0 < w_p1) ? w_p0 : w_p1;
   assign w_min23 = (w_p2 < w_p3) ? w_p2 : w_p3;
   assign w_min   = (w_min01 < w_min23) ? w_min01 : w_min23;
`endif

   // New window contents for the latched command; shifts and no-ops write the pixels back unchanged.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case can infer a latch.
      w_n0 = w_p0;
      w_n1 = w_p1;
      w_n2 = w_p2;
      w_n3 = w_p3;
      case (r_cmd)
         CMD_AVG: begin
            w_n0 = w_avg;
            w_n1 = w_avg;
            w_n2 = w_avg;
            w_n3 = w_avg;
         end
         CMD_MIRX: begin
            w_n0 = w_p2;
            w_n1 = w_p3;
            w_n2 = w_p0;
            w_n3 = w_p1;
         end
         CMD_MIRY: begin
            w_n0 = w_p1;
            w_n1 = w_p0;
            w_n2 = w_p3;
            w_n3 = w_p2;
         end
`ifdef LCD_CTRL_MAXMIN_EN
         CMD_MAX: begin
            w_n0 = w_max;
            w_n1 = w_max;
            w_n2 = w_max;
            w_n3 = w_max;
         end
         CMD_MIN: begin
            w_n0 = w_min;
            w_n1 = w_min;
            w_n2 = w_min;
            w_n3 = w_min;
         end
`endif
         default: ;
      endcase
   end

   // NOTE: the frame buffer has no reset; it is always refilled from IROM before it is read.
   always_ff @(posedge clk) begin
      if (r_state == S_LOAD && !r_irom_en) begin
         r_buf[r_irom_a] <= bus.IROM_Q;
      end else if (r_state == S_EXEC) begin
         r_buf[w_a0] <= w_n0;
         r_buf[w_a1] <= w_n1;
         r_buf[w_a2] <= w_n2;
         r_buf[w_a3] <= w_n3;
      end
   end

   // NOTE: all state and outputs use non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= S_LOAD;
         r_x       <= X_MID;
         r_y       <= Y_MID;
         r_cmd     <= CMD_WRITE;
         r_irom_en <= 1'b1;
         r_irom_a  <= A_ZERO;
         r_irb_rw  <= 1'b1;
         r_irb_d   <= '0;
         r_irb_a   <= A_ZERO;
         r_busy    <= 1'b1;
         r_done    <= 1'b0;
      end else begin
         case (r_state)
            // First edge only enables IROM; each later edge captures the pixel at r_irom_a.
            S_LOAD: begin
               if (r_irom_en) begin
                  r_irom_en <= 1'b0;
                  r_irom_a  <= A_ZERO;
               end else if (r_irom_a == A_LAST) begin
                  r_irom_en <= 1'b1;
                  r_state   <= S_IDLE;
               end else begin
                  r_irom_a <= r_irom_a + A_ONE;
               end
            end

            // Arriving from LOAD, busy is still high for one cycle before commands are taken.
            S_IDLE: begin
               if (r_busy) begin
                  r_busy <= 1'b0;
               end else if (bus.cmd_valid) begin
                  r_busy <= 1'b1;
                  r_cmd  <= bus.cmd;
                  if (bus.cmd == CMD_WRITE) begin
                     r_state  <= S_WRITE;
                     r_irb_rw <= 1'b0;
                     r_irb_a  <= A_ZERO;
                     r_irb_d  <= r_buf[A_ZERO];
                  end else begin
                     r_state <= S_EXEC;
                  end
               end
            end

            S_EXEC: begin
               case (r_cmd)
                  CMD_UP:    if (r_y != Y_ONE) r_y <= w_ym1;
                  CMD_DOWN:  if (r_y != Y_MAX) r_y <= r_y + Y_ONE;
                  CMD_LEFT:  if (r_x != X_ONE) r_x <= w_xm1;
                  CMD_RIGHT: if (r_x != X_MAX) r_x <= r_x + X_ONE;
                  default: ;
               endcase
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            S_WRITE: begin
               if (r_irb_a == A_LAST) begin
                  r_irb_rw <= 1'b1;
                  r_done   <= 1'b1;
                  r_state  <= S_DONE;
               end else begin
                  r_irb_a <= w_irb_next;
                  r_irb_d <= r_buf[w_irb_next];
               end
            end

            S_DONE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: r_state <= S_LOAD;
         endcase
      end
   end

   assign bus.IROM_EN = r_irom_en;
   assign bus.IROM_A  = r_irom_a;
   assign bus.IRB_RW  = r_irb_rw;
   assign bus.IRB_D   = r_irb_d;
   assign bus.IRB_A   = r_irb_a;
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Scoreboard bench for lcd_ctrl_param: directed commands push expected IRB writes into a queue,
// an independent monitor pops and compares each IRB write. Honours LCD_CTRL_MAXMIN_EN.
`timescale 1ns/1ps
module tb_lcd_ctrl_param;
   localparam int IMG_W = 8;
   localparam int IMG_H = 8;
   localparam int DW    = 8;
   localparam int N     = IMG_W * IMG_H;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   lcd_ctrl_param_if #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW)) bus ();

   lcd_ctrl_param #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // IROM holds value = address, read combinationally.
   logic [DW-1:0] rom [N];
   assign bus.IROM_Q = rom[bus.IROM_A];

   int n_vec = 0;
   int n_err = 0;
   int mimg [N];
   int exp_addr_q [$];
   int exp_data_q [$];

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: every IRB write must match the head of the scoreboard queue.
   always @(negedge clk) begin
      if (reset && bus.IRB_RW == 1'b0) begin
         if (exp_addr_q.size() == 0) begin
            check("irb_unexpected_write", exp_addr_q.size(), 1);
         end else begin
            check("irb_addr", int'(bus.IRB_A), exp_addr_q.pop_front());
            check("irb_data", int'(bus.IRB_D), exp_data_q.pop_front());
         end
      end
   end

   task automatic model_reload();
      for (int k = 0; k < N; k++) mimg[k] = k;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_irom_en"}, int'(bus.IROM_EN), 1);
      check({tag, "_irom_a"},  int'(bus.IROM_A),  0);
      check({tag, "_irb_rw"},  int'(bus.IRB_RW),  1);
      check({tag, "_irb_d"},   int'(bus.IRB_D),   0);
      check({tag, "_irb_a"},   int'(bus.IRB_A),   0);
      check({tag, "_busy"},    int'(bus.busy),    1);
      check({tag, "_done"},    int'(bus.done),    0);
   endtask

   // Called just after the edge preceding the first LOAD edge; busy must fall 65 edges after it.
   task automatic load_wait();
      int cnt;
      @(posedge clk); #1;
      check("load_irom_en_low", int'(bus.IROM_EN), 0);
      check("load_busy", int'(bus.busy), 1);
      cnt = 0;
      do begin
         @(posedge clk); #1;
         cnt++;
      end while (bus.busy && cnt < 200);
      check("load_busy_cycles", cnt, N + 1);
      check("load_irom_en_idle", int'(bus.IROM_EN), 1);
   endtask

   task automatic full_reset(input string tag);
      reset = 1'b0;
      #1;
      check_reset_vals(tag);
      exp_addr_q.delete();
      exp_data_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      model_reload();
      load_wait();
   endtask

   task automatic issue(input logic [3:0] c);
      bus.cmd       = c;
      bus.cmd_valid = 1'b1;
      @(posedge clk); #1;
      check("accept_busy", int'(bus.busy), 1);
      bus.cmd_valid = 1'b0;
   endtask

   task automatic exec_cmd(input logic [3:0] c);
      issue(c);
      @(posedge clk); #1;
      check("exec_busy_clear", int'(bus.busy), 0);
      check("exec_done_low", int'(bus.done), 0);
   endtask

   task automatic push_frame();
      for (int k = 0; k < N; k++) begin
         exp_addr_q.push_back(k);
         exp_data_q.push_back(mimg[k]);
      end
   endtask

   // hold=1 keeps cmd_valid asserted (with a shift command) for the whole WRITE.
   task automatic write_frame(input bit hold);
      int cnt;
      push_frame();
      issue(4'd0);
      if (hold) begin
         bus.cmd       = 4'd3;
         bus.cmd_valid = 1'b1;
      end
      cnt = 0;
      while (!bus.done && cnt < 200) begin
         @(posedge clk); #1;
         cnt++;
      end
      bus.cmd_valid = 1'b0;
      check("done_latency", cnt, N);
      check("done_busy_high", int'(bus.busy), 1);
      check("done_irb_rw_high", int'(bus.IRB_RW), 1);
      @(posedge clk); #1;
      check("done_pulse_end", int'(bus.done), 0);
      check("post_done_busy", int'(bus.busy), 0);
      check("irb_queue_drained", exp_addr_q.size(), 0);
      exp_addr_q.delete();
      exp_data_q.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, bench did not finish");
      $fatal(1);
   end

   initial begin
      int cnt;
      bus.cmd       = 4'd0;
      bus.cmd_valid = 1'b0;
      for (int k = 0; k < N; k++) rom[k] = DW'(k);
      model_reload();

      // Reset values, then initial load timing.
      reset = 1'b0;
      @(posedge clk); #1;
      check_reset_vals("rst");
      @(posedge clk); #1;
      reset = 1'b1;
      load_wait();

      // Identity frame out, with cmd_valid held high throughout the write.
      write_frame(1'b1);

      // Average at (4,4): 27+28+35+36 = 126 -> 31.
      exec_cmd(4'd5);
      mimg[27] = 31; mimg[28] = 31; mimg[35] = 31; mimg[36] = 31;
      write_frame(1'b0);

      // Up five times stops at y=1; mirror X swaps pixels 3,4 with 11,12.
      repeat (5) exec_cmd(4'd1);
      exec_cmd(4'd6);
      mimg[3] = 11; mimg[4] = 12; mimg[11] = 3; mimg[12] = 4;
      write_frame(1'b0);

      // Mirror Y at the same point swaps columns 3 and 4 of rows 0 and 1.
      exec_cmd(4'd7);
      mimg[3] = 12; mimg[4] = 11; mimg[11] = 4; mimg[12] = 3;
      write_frame(1'b0);

      // Right five times stops at x=7; average of 6,7,14,15 = 42 -> 10 (truncated); cmd 12 is a no-op.
      repeat (5) exec_cmd(4'd4);
      exec_cmd(4'd5);
      mimg[6] = 10; mimg[7] = 10; mimg[14] = 10; mimg[15] = 10;
      exec_cmd(4'd12);
      write_frame(1'b0);

      // Reset in the middle of a write, at IRB_A=20.
      push_frame();
      issue(4'd0);
      cnt = 0;
      while (int'(bus.IRB_A) != 20 && cnt < 200) begin
         @(posedge clk); #1;
         cnt++;
      end
      check("reach_irb_a_20", int'(bus.IRB_A), 20);
      check("mid_write_rw_low", int'(bus.IRB_RW), 0);
      full_reset("midwr");

      // Max at (4,4) after reload.
      exec_cmd(4'd8);
`ifdef LCD_CTRL_MAXMIN_EN
      mimg[27] = 36; mimg[28] = 36; mimg[35] = 36; mimg[36] = 36;
`endif
      write_frame(1'b0);

      // Fresh reload, min at (4,4).
      @(posedge clk); #1;
      full_reset("rst2");
      exec_cmd(4'd9);
`ifdef LCD_CTRL_MAXMIN_EN
      mimg[27] = 27; mimg[28] = 27; mimg[35] = 27; mimg[36] = 27;
`endif
      write_frame(1'b0);

      // Down to (4,5), then average of pixels 35,36,43,44.
      exec_cmd(4'd15);
      exec_cmd(4'd2);
      exec_cmd(4'd5);
`ifdef LCD_CTRL_MAXMIN_EN
      // 27+27+43+44 = 141 -> 35
      mimg[35] = 35; mimg[36] = 35; mimg[43] = 35; mimg[44] = 35;
`else
      // 35+36+43+44 = 158 -> 39
      mimg[35] = 39; mimg[36] = 39; mimg[43] = 39; mimg[44] = 39;
`endif
      write_frame(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
